// File: rtl/hex_piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on START and shifts it out MSB-first
// with a generated SCLK and active-low frame select. Define HEX_PISO_PARITY_EN to append an even-parity bit.
module hex_piso_tx #(
  parameter int WIDTH = 6,
  parameter int HALF  = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  output logic             SDO,
  output logic             SCLK,
  output logic             FRAME_N,
  output logic             BUSY,
  output logic             DONE
);

`ifdef HEX_PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int HALF_W = $clog2(HALF + 1);
  localparam int BIT_W  = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NBITS-1:0]      shreg_q, shreg_d;
  logic [HALF_W-1:0]     half_cnt_q, half_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sdo_q, sdo_d;
  logic                  sclk_q, sclk_d;
  logic                  frame_n_q, frame_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NBITS-1:0]      shifted;

  // Word as it goes on the wire; the parity bit (when enabled) trails the data LSB.
  function automatic logic [NBITS-1:0] load_word(input logic [WIDTH-1:0] d);
`ifdef HEX_PISO_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  assign shifted = shreg_q << 1;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sdo_d      = sdo_q;
    sclk_d     = sclk_q;
    frame_n_d  = frame_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        sdo_d     = 1'b1;
        sclk_d    = 1'b0;
        frame_n_d = 1'b1;
        busy_d    = 1'b0;
        if (START) begin
          shreg_d    = load_word(D);
          sdo_d      = D[WIDTH-1];
          frame_n_d  = 1'b0;
          busy_d     = 1'b1;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (half_cnt_q == HALF_W'(HALF - 1)) begin
          half_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: SDO moves only together with the SCLK fall.
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_W'(NBITS - 1)) begin
              sdo_d     = 1'b1;
              frame_n_d = 1'b1;
              done_d    = 1'b1;
              state_d   = S_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shreg_d   = shifted;
              sdo_d     = shifted[NBITS-1];
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end

      S_DONE: begin
        sdo_d     = 1'b1;
        sclk_d    = 1'b0;
        frame_n_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        sdo_d     = 1'b1;
        sclk_d    = 1'b0;
        frame_n_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sdo_q      <= 1'b1;
      sclk_q     <= 1'b0;
      frame_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sdo_q      <= sdo_d;
      sclk_q     <= sclk_d;
      frame_n_q  <= frame_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SDO     = sdo_q;
  assign SCLK    = sclk_q;
  assign FRAME_N = frame_n_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_hex_piso_tx.sv
// Self-checking bench for hex_piso_tx: serial bits go through a scoreboard queue popped on SCLK rise.
module tb_hex_piso_tx;
  localparam int WIDTH = 6;
  localparam int HALF  = 2;
`ifdef HEX_PISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int FLEN = 2 * HALF * NB;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic             START = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic             SDO, SCLK, FRAME_N, BUSY, DONE;

  hex_piso_tx #(.WIDTH(WIDTH), .HALF(HALF)) dut (
    .CLK(CLK), .CLR(CLR), .D(D), .START(START),
    .SDO(SDO), .SCLK(SCLK), .FRAME_N(FRAME_N), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  bit exp_q[$];
  bit exp_b;
  int low_run = 0, hi_run = 0, last_low = 0, last_hi = 0, done_cnt = 0;
  logic sclk_prev = 1'b0, frame_prev = 1'b1;

  // Monitor: pops an expected bit on every SCLK rise and measures FRAME_N runs.
  initial begin
    forever begin
      @(negedge CLK);
      if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sdo_bit: unexpected SCLK rise at cyc %0d, SDO=%b, no bit expected", cyc, SDO);
        end else begin
          exp_b = exp_q.pop_front();
          if (SDO !== exp_b) begin
            bad++;
            $display("FAIL sdo_bit: cyc %0d got SDO=%b expected %b", cyc, SDO, exp_b);
          end
        end
      end
      if (FRAME_N === 1'b0) begin
        if (frame_prev === 1'b1) begin last_hi = hi_run; low_run = 0; end
        low_run++;
      end else begin
        if (frame_prev === 1'b0) begin last_low = low_run; hi_run = 0; end
        hi_run++;
      end
      if (DONE === 1'b1) done_cnt++;
      sclk_prev  = SCLK;
      frame_prev = FRAME_N;
    end
  end

  task automatic push_frame(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef HEX_PISO_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  task automatic start_frame(input logic [WIDTH-1:0] d, output int cap);
    @(posedge CLK); #1;
    D = d; START = 1'b1;
    push_frame(d);
    @(posedge CLK); #1;
    cap = cyc;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK); #1;
      if (DONE === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (SDO !== 1'b1)     begin bad++; $display("FAIL reset_sdo: got %b expected 1", SDO); end
    total++; if (SCLK !== 1'b0)    begin bad++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
    total++; if (FRAME_N !== 1'b1) begin bad++; $display("FAIL reset_frame_n: got %b expected 1", FRAME_N); end
    total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    total++; if (DONE !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b expected 0", DONE); end
    @(posedge CLK); #2;
    CLR = 1'b1;
  endtask

  task automatic test_basic();
    int cap, base;
    bit ok;
    logic [WIDTH-1:0] d;
    d = 6'b101101;
    base = done_cnt;
    start_frame(d, cap);
    total++; if (FRAME_N !== 1'b0) begin bad++; $display("FAIL basic_capture_frame_n: got %b expected 0", FRAME_N); end
    total++; if (BUSY !== 1'b1)    begin bad++; $display("FAIL basic_capture_busy: got %b expected 1", BUSY); end
    total++; if (SDO !== d[WIDTH-1]) begin bad++; $display("FAIL basic_capture_sdo: got %b expected %b", SDO, d[WIDTH-1]); end
    total++; if (SCLK !== 1'b0)    begin bad++; $display("FAIL basic_capture_sclk: got %b expected 0", SCLK); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout: no DONE within 200 cycles"); end
    total++; if (cyc - cap + 1 != FLEN + 1) begin bad++; $display("FAIL basic_done_edge: got edge %0d expected %0d", cyc - cap + 1, FLEN + 1); end
    total++; if (last_low != FLEN) begin bad++; $display("FAIL basic_frame_len: got %0d expected %0d", last_low, FLEN); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done: got %b expected 1", BUSY); end
    @(negedge CLK); #1;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b expected 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b expected 0", DONE); end
    total++; if (done_cnt - base != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - base); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_bits_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_data_stable();
    int cap;
    bit ok;
    start_frame(6'h2A, cap);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (DONE === 1'b1) begin ok = 1'b1; break; end
      D = WIDTH'($urandom);
    end
    total++; if (!ok) begin bad++; $display("FAIL stable_done_timeout: no DONE within 200 cycles"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stable_bits_left: got %0d expected 0", exp_q.size()); end
    total++; if (last_low != FLEN) begin bad++; $display("FAIL stable_frame_len: got %0d expected %0d", last_low, FLEN); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_start_ignored();
    int cap, base;
    bit ok;
    base = done_cnt;
    start_frame(6'h15, cap);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin ok = 1'b1; break; end
      START = ((cyc - cap) == 5) || ((cyc - cap) == 12);
    end
    START = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL ignore_done_timeout: no DONE within 200 cycles"); end
    repeat (6) @(posedge CLK);
    #1;
    total++; if (done_cnt - base != 1) begin bad++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - base); end
    total++; if (last_low != FLEN) begin bad++; $display("FAIL ignore_frame_len: got %0d expected %0d", last_low, FLEN); end
    total++; if (FRAME_N !== 1'b1) begin bad++; $display("FAIL ignore_no_queue: FRAME_N got %b expected 1", FRAME_N); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL ignore_busy: got %b expected 0", BUSY); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ignore_bits_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cap, base;
    bit ok;
    base = done_cnt;
    start_frame(6'h2D, cap);
    repeat (13) @(posedge CLK);
    #1;
    CLR = 1'b0;
    #1;
    total++; if (SDO !== 1'b1)     begin bad++; $display("FAIL abort_sdo: got %b expected 1", SDO); end
    total++; if (SCLK !== 1'b0)    begin bad++; $display("FAIL abort_sclk: got %b expected 0", SCLK); end
    total++; if (FRAME_N !== 1'b1) begin bad++; $display("FAIL abort_frame_n: got %b expected 1", FRAME_N); end
    total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    #2;
    CLR = 1'b1;
    exp_q.delete();
    repeat (30) @(negedge CLK);
    #1;
    total++; if (done_cnt != base) begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - base); end
    total++; if (FRAME_N !== 1'b1) begin bad++; $display("FAIL abort_idle: FRAME_N got %b expected 1", FRAME_N); end
    start_frame(6'h33, cap);
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_refr_timeout: no DONE within 200 cycles"); end
    total++; if (last_low != FLEN) begin bad++; $display("FAIL abort_refr_len: got %0d expected %0d", last_low, FLEN); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_refr_bits: got %0d expected 0", exp_q.size()); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    base = done_cnt;
    @(posedge CLK); #1;
    D = 6'h3F; START = 1'b1;
    push_frame(6'h3F);
    push_frame(6'h00);
    @(posedge CLK); #1;
    D = 6'h00;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout: no DONE within 200 cycles"); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (FRAME_N === 1'b0) begin ok = 1'b1; break; end
    end
    START = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL b2b_restart_timeout: second frame did not start"); end
    total++; if (last_hi != 2) begin bad++; $display("FAIL b2b_gap: FRAME_N high %0d cycles expected 2", last_hi); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout: no DONE within 200 cycles"); end
    total++; if (last_low != FLEN) begin bad++; $display("FAIL b2b_frame_len: got %0d expected %0d", last_low, FLEN); end
    repeat (6) @(negedge CLK);
    #1;
    total++; if (done_cnt - base != 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - base); end
    total++; if (FRAME_N !== 1'b1) begin bad++; $display("FAIL b2b_no_third: FRAME_N got %b expected 1", FRAME_N); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_bits_left: got %0d expected 0", exp_q.size()); end
  endtask

`ifdef HEX_PISO_PARITY_EN
  task automatic test_parity();
    int cap;
    bit ok;
    logic [WIDTH-1:0] words [2];
    words[0] = 6'b101100;
    words[1] = 6'b101101;
    for (int w = 0; w < 2; w++) begin
      start_frame(words[w], cap);
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL parity_timeout: word %0d no DONE", w); end
      total++; if (cyc - cap + 1 != FLEN + 1) begin bad++; $display("FAIL parity_done_edge: got %0d expected %0d", cyc - cap + 1, FLEN + 1); end
      total++; if (last_low != FLEN) begin bad++; $display("FAIL parity_frame_len: got %0d expected %0d", last_low, FLEN); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL parity_bits_left: got %0d expected 0", exp_q.size()); end
      repeat (2) @(posedge CLK);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_data_stable();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef HEX_PISO_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
